// File: rtl/tile_buf_pkg.sv
// -----------------------------------------------------------------------------
// tile_buf_pkg
//   Shared definitions for the tile buffer arbiter slice: default geometry of
//   the single-port SRAM, the arbiter FSM state encoding, the round-robin
//   grant marker and the active-low SRAM control levels.
// -----------------------------------------------------------------------------
package tile_buf_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int ADDR_WIDTH_DEF = 11;
  localparam int NUM_WMASKS_DEF = 8;
  localparam int RD_LAT_DEF     = 6;

  // SRAM strobes are active low.
  localparam logic ACT_LO_TRUE  = 1'b0;
  localparam logic ACT_LO_FALSE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WR0,
    WR1,
    WR2,
    RD,
    RDW
  } state_e;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

endpackage

// File: rtl/tile_bank_tracker.sv
// -----------------------------------------------------------------------------
// tile_bank_tracker
//   Ping-pong bookkeeping for the two SRAM banks. The writer fills wr_bank and
//   hands it over with w_tile_done; the reader drains rd_bank and releases it
//   with r_tile_done. A done pulse is ignored while its side is not ready.
//
//   clk, rst      : clock, asynchronous active-high reset
//   w_tile_done   : writer finished its current bank
//   r_tile_done   : reader finished its current bank
//   wr_bank       : bank the writer is filling
//   rd_bank       : bank the reader is draining
//   w_bank_ready  : writer's bank is empty
//   r_bank_ready  : reader's bank is full
// -----------------------------------------------------------------------------
module tile_bank_tracker (
  input  logic clk,
  input  logic rst,
  input  logic w_tile_done,
  input  logic r_tile_done,
  output logic wr_bank,
  output logic rd_bank,
  output logic w_bank_ready,
  output logic r_bank_ready
);

  logic [1:0] full;
  logic       w_take;
  logic       r_take;

  assign w_bank_ready = !full[wr_bank];
  assign r_bank_ready = full[rd_bank];

  assign w_take = w_tile_done & w_bank_ready;
  assign r_take = r_tile_done & r_bank_ready;

  // When both sides take in the same cycle they address different banks:
  // the writer's bank is empty and the reader's bank is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so the order of these statements does not matter.
      if (w_take) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= !wr_bank;
      end
      if (r_take) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= !rd_bank;
      end
    end
  end

endmodule

// File: rtl/tile_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// tile_buffer_arbiter
//   Shares one single-port SRAM between a tile writer and a PE-feeder reader.
//   Writes hold the SRAM strobes low for three cycles; reads issue for one
//   cycle and wait RD_LAT cycles for sram_dout. Ties alternate round-robin.
//
//   clk, rst                        : clock, asynchronous active-high reset
//   w_req/w_addr/w_data/w_wmask     : write request, held until w_ack
//   w_ack                           : one-cycle write-complete pulse
//   w_tile_done, w_bank_ready       : writer bank hand-over / bank empty
//   r_req/r_addr                    : read request, held until r_ack
//   r_data, r_ack                   : read word, valid with r_ack pulse
//   r_tile_done, r_bank_ready       : reader bank release / bank full
//   sram_csb/we/addr/din/wmask      : SRAM drive (csb, we active low)
//   sram_dout                       : SRAM read data
// -----------------------------------------------------------------------------
module tile_buffer_arbiter
  import tile_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_WMASKS = NUM_WMASKS_DEF,
  parameter int RD_LAT     = RD_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_req,
  input  logic [ADDR_WIDTH-2:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [NUM_WMASKS-1:0] w_wmask,
  output logic                  w_ack,
  input  logic                  w_tile_done,
  output logic                  w_bank_ready,
  input  logic                  r_req,
  input  logic [ADDR_WIDTH-2:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_ack,
  input  logic                  r_tile_done,
  output logic                  r_bank_ready,
  output logic                  sram_csb,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  // RDW counts 0 .. RD_LAT-1; the last value is the cycle sram_dout is valid.
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e           state;
  state_e           state_next;
  grant_e           last_grant;
  logic [CNT_W-1:0] rd_cnt;
  logic             wr_bank;
  logic             rd_bank;
  logic             w_elig;
  logic             r_elig;
  logic             grant_w;
  logic             grant_r;
  logic             rd_done;

  tile_bank_tracker u_bank_tracker (
    .clk          (clk),
    .rst          (rst),
    .w_tile_done  (w_tile_done),
    .r_tile_done  (r_tile_done),
    .wr_bank      (wr_bank),
    .rd_bank      (rd_bank),
    .w_bank_ready (w_bank_ready),
    .r_bank_ready (r_bank_ready)
  );

  // Arbitration: a lone eligible side wins; a tie goes to the side that was
  // not granted last.
  assign w_elig  = w_req & w_bank_ready;
  assign r_elig  = r_req & r_bank_ready;
  assign grant_w = (state == IDLE) & w_elig & (!r_elig | (last_grant == GRANT_RD));
  assign grant_r = (state == IDLE) & r_elig & !grant_w;
  assign rd_done = (state == RDW) && (rd_cnt == CNT_W'(RD_LAT - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment up front keeps this purely combinational;
    // a path that left state_next unassigned would infer a latch.
    state_next = state;
    unique case (state)
      IDLE: begin
        if (grant_w)      state_next = WR0;
        else if (grant_r) state_next = RD;
      end
      WR0:     state_next = WR1;
      WR1:     state_next = WR2;
      WR2:     state_next = IDLE;
      RD:      state_next = RDW;
      RDW:     if (rd_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // SRAM strobes are decoded from state so reset releases them immediately.
  always_comb begin
    sram_csb = ACT_LO_FALSE;
    sram_we  = ACT_LO_FALSE;
    unique case (state)
      WR0, WR1, WR2: begin
        sram_csb = ACT_LO_TRUE;
        sram_we  = ACT_LO_TRUE;
      end
      RD:      sram_csb = ACT_LO_TRUE;
      default: ;
    endcase
  end

  // Request capture at grant, read latency counter and completion outputs.
  // The bank is latched with the address so a tile_done during the access
  // cannot redirect it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr  <= '0;
      sram_din   <= '0;
      sram_wmask <= '0;
      last_grant <= GRANT_RD;
      rd_cnt     <= '0;
      w_ack      <= 1'b0;
      r_ack      <= 1'b0;
      r_data     <= '0;
    end else begin
      w_ack <= (state == WR2);
      r_ack <= rd_done;

      if (grant_w) begin
        sram_addr  <= {wr_bank, w_addr};
        sram_din   <= w_data;
        sram_wmask <= w_wmask;
        last_grant <= GRANT_WR;
      end else if (grant_r) begin
        sram_addr  <= {rd_bank, r_addr};
        last_grant <= GRANT_RD;
      end

      if (state == RDW) rd_cnt <= rd_done ? '0 : rd_cnt + CNT_W'(1);
      if (rd_done)      r_data <= sram_dout;
    end
  end

endmodule
